// File: rtl/bldc_commutator.sv
// bldc_commutator
//   Six-step BLDC commutation engine. Synchronises and debounces the three
//   hall inputs, decodes them to a sector, and drives the six bridge gate
//   enables through an OFF/DEAD/DRIVE sequencer that inserts dead time on every
//   pattern change. It also keeps a signed step count and the period between
//   the last two counted steps.
//
// Ports
//   CLK          system clock
//   reset_n      asynchronous active-low reset
//   hall[2:0]    raw hall inputs {hall1,hall2,hall3}, asynchronous
//   enable       1 = drive bridge, 0 = all gates off
//   dir          1 = forward table, 0 = reverse table
//   brake        1 = all low sides on (needs enable, overrides dir)
//   deadtime     dead-time length in CLK cycles (0 behaves as 1)
//   pwm_in       PWM chopping applied to the high sides
//   gate_h[2:0]  {INHA,INHB,INHC}
//   gate_l[2:0]  {INLA,INLB,INLC}
//   sector[2:0]  decoded sector 0..5, 7 = unknown/invalid
//   hall_fault   accepted hall code is 000 or 111
//   step_error   one-cycle pulse on a non-adjacent sector jump
//   step_count   signed commutation step count
//   step_period  CLK cycles between the last two counted steps
//   period_valid step_period is meaningful
//
// Gate sequencer states
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_OFF   | all gates off, target is all-off
//   ST_DEAD  | all gates off, counting dead time before the next pattern
//   ST_DRIVE | pattern latched and driven to the bridge

module bldc_commutator #(
  parameter int HALL_FILTER_CYCLES = 16,
  parameter int DEADTIME_WIDTH     = 10,
  parameter int PERIOD_WIDTH       = 24
) (
  input  logic                      CLK,
  input  logic                      reset_n,
  input  logic [2:0]                hall,
  input  logic                      enable,
  input  logic                      dir,
  input  logic                      brake,
  input  logic [DEADTIME_WIDTH-1:0] deadtime,
  input  logic                      pwm_in,
  output logic [2:0]                gate_h,
  output logic [2:0]                gate_l,
  output logic [2:0]                sector,
  output logic                      hall_fault,
  output logic                      step_error,
  output logic [31:0]               step_count,
  output logic [PERIOD_WIDTH-1:0]   step_period,
  output logic                      period_valid
);

  localparam int FCW = $clog2(HALL_FILTER_CYCLES + 1);
  localparam logic [FCW-1:0] FILT_N = FCW'(HALL_FILTER_CYCLES);
  localparam logic [PERIOD_WIDTH-1:0] PER_MAX = '1;
  localparam logic [PERIOD_WIDTH-1:0] PER_SAT = PER_MAX - PERIOD_WIDTH'(1);
  localparam logic [2:0] SEC_NONE = 3'd7;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_DEAD  = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  function automatic logic [2:0] decode_hall(input logic [2:0] h);
    logic [2:0] s;
    case (h)
      3'b101:  s = 3'd0;
      3'b100:  s = 3'd1;
      3'b110:  s = 3'd2;
      3'b010:  s = 3'd3;
      3'b011:  s = 3'd4;
      3'b001:  s = 3'd5;
      default: s = SEC_NONE;
    endcase
    return s;
  endfunction

  function automatic logic [2:0] sec_inc(input logic [2:0] s);
    return (s == 3'd5) ? 3'd0 : s + 3'd1;
  endfunction

  function automatic logic [2:0] sec_dec(input logic [2:0] s);
    return (s == 3'd0) ? 3'd5 : s - 3'd1;
  endfunction

  // ---------------------------------------------------------------------
  // Hall synchroniser and debounce filter
  // ---------------------------------------------------------------------
  logic [2:0]     hall_s1_q, hall_s2_q;
  logic [2:0]     hall_cand_q, hall_cand_d;
  logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
  logic           accept;

  // The counter holds the number of consecutive equal synchronised samples,
  // including the current one, so a code is accepted on the same edge its
  // HALL_FILTER_CYCLES-th sample is seen.
  always_comb begin
    hall_cand_d = hall_cand_q;
    filt_cnt_d  = filt_cnt_q;
    if (hall_s2_q != hall_cand_q) begin
      hall_cand_d = hall_s2_q;
      filt_cnt_d  = FCW'(1);
    end else if (filt_cnt_q != FILT_N) begin
      filt_cnt_d = filt_cnt_q + FCW'(1);
    end
    accept = (filt_cnt_d == FILT_N);
  end

  // ---------------------------------------------------------------------
  // Sector decode, step counting, step period
  // ---------------------------------------------------------------------
  logic [2:0]              sector_q, sector_d;
  logic                    hall_fault_q, hall_fault_d;
  logic                    step_err_q, step_err_d;
  logic [31:0]             step_count_q, step_count_d;
  logic [PERIOD_WIDTH-1:0] per_cnt_q, per_cnt_d;
  logic [PERIOD_WIDTH-1:0] step_period_q, step_period_d;
  logic                    period_valid_q, period_valid_d;
  logic                    per_armed_q, per_armed_d;
  logic [2:0]              new_sec;
  logic                    counted;

  always_comb begin
    new_sec      = decode_hall(hall_s2_q);
    sector_d     = sector_q;
    hall_fault_d = hall_fault_q;
    step_err_d   = 1'b0;
    step_count_d = step_count_q;
    counted      = 1'b0;
    if (accept) begin
      sector_d     = new_sec;
      hall_fault_d = (new_sec == SEC_NONE);
      if (sector_q != SEC_NONE && new_sec != SEC_NONE && new_sec != sector_q) begin
        if (new_sec == sec_inc(sector_q)) begin
          step_count_d = step_count_q + 32'd1;
          counted      = 1'b1;
        end else if (new_sec == sec_dec(sector_q)) begin
          step_count_d = step_count_q - 32'd1;
          counted      = 1'b1;
        end else begin
          step_err_d = 1'b1;
        end
      end
    end
  end

  // per_armed marks that a counted step has been seen since reset or the last
  // saturation, so the next step measures a real interval. Saturation is
  // taken on the cycle the counter reaches all-ones; a step on that same
  // cycle takes priority and reports the full-scale period.
  always_comb begin
    per_cnt_d      = (per_cnt_q == PER_MAX) ? per_cnt_q : per_cnt_q + PERIOD_WIDTH'(1);
    step_period_d  = step_period_q;
    period_valid_d = period_valid_q;
    per_armed_d    = per_armed_q;
    if (counted) begin
      per_cnt_d   = '0;
      per_armed_d = 1'b1;
      if (per_armed_q) begin
        step_period_d  = per_cnt_q + PERIOD_WIDTH'(1);
        period_valid_d = 1'b1;
      end
    end else if (per_cnt_q == PER_SAT) begin
      period_valid_d = 1'b0;
      per_armed_d    = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      hall_s1_q      <= '0;
      hall_s2_q      <= '0;
      hall_cand_q    <= '0;
      filt_cnt_q     <= '0;
      sector_q       <= SEC_NONE;
      hall_fault_q   <= 1'b0;
      step_err_q     <= 1'b0;
      step_count_q   <= '0;
      per_cnt_q      <= '0;
      step_period_q  <= '0;
      period_valid_q <= 1'b0;
      per_armed_q    <= 1'b0;
    end else begin
      hall_s1_q      <= hall;
      hall_s2_q      <= hall_s1_q;
      hall_cand_q    <= hall_cand_d;
      filt_cnt_q     <= filt_cnt_d;
      sector_q       <= sector_d;
      hall_fault_q   <= hall_fault_d;
      step_err_q     <= step_err_d;
      step_count_q   <= step_count_d;
      per_cnt_q      <= per_cnt_d;
      step_period_q  <= step_period_d;
      period_valid_q <= period_valid_d;
      per_armed_q    <= per_armed_d;
    end
  end

  // ---------------------------------------------------------------------
  // Target pattern {high[2:0], low[2:0]}
  // ---------------------------------------------------------------------
  logic [5:0] tgt;

  always_comb begin
    tgt = '0;
    if (enable && sector_q != SEC_NONE) begin
      if (brake) begin
        tgt = 6'b000_111;
      end else begin
        case ({dir, sector_q})
          4'b1_000: tgt = 6'b001_010;
          4'b1_001: tgt = 6'b100_010;
          4'b1_010: tgt = 6'b100_001;
          4'b1_011: tgt = 6'b010_001;
          4'b1_100: tgt = 6'b010_100;
          4'b1_101: tgt = 6'b001_100;
          4'b0_000: tgt = 6'b010_001;
          4'b0_001: tgt = 6'b010_100;
          4'b0_010: tgt = 6'b001_100;
          4'b0_011: tgt = 6'b001_010;
          4'b0_100: tgt = 6'b100_010;
          4'b0_101: tgt = 6'b100_001;
          default:  tgt = 6'b000_000;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------
  // Gate sequencer
  // ---------------------------------------------------------------------
  state_t                    state_q, state_d;
  logic [5:0]                pat_q, pat_d;
  logic [5:0]                dead_tgt_q, dead_tgt_d;
  logic [DEADTIME_WIDTH-1:0] dt_cnt_q, dt_cnt_d;
  logic [DEADTIME_WIDTH-1:0] dt_load;

  assign dt_load = (deadtime == '0) ? DEADTIME_WIDTH'(1) : deadtime;

  // dead_tgt remembers the target that started the current dead period, so
  // a target change while waiting restarts the full dead time.
  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    dead_tgt_d = dead_tgt_q;
    dt_cnt_d   = dt_cnt_q;
    case (state_q)
      ST_OFF: begin
        pat_d = '0;
        if (tgt != '0) begin
          state_d    = ST_DEAD;
          dt_cnt_d   = dt_load;
          dead_tgt_d = tgt;
        end
      end
      ST_DEAD: begin
        pat_d = '0;
        if (tgt == '0) begin
          state_d = ST_OFF;
        end else if (tgt != dead_tgt_q) begin
          dt_cnt_d   = dt_load;
          dead_tgt_d = tgt;
        end else if (dt_cnt_q == DEADTIME_WIDTH'(1)) begin
          state_d = ST_DRIVE;
          pat_d   = tgt;
        end else begin
          dt_cnt_d = dt_cnt_q - DEADTIME_WIDTH'(1);
        end
      end
      ST_DRIVE: begin
        if (tgt == '0) begin
          state_d = ST_OFF;
          pat_d   = '0;
        end else if (tgt != pat_q) begin
          state_d    = ST_DEAD;
          pat_d      = '0;
          dt_cnt_d   = dt_load;
          dead_tgt_d = tgt;
        end
      end
      default: begin
        state_d = ST_OFF;
        pat_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_OFF;
      pat_q      <= '0;
      dead_tgt_q <= '0;
      dt_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      dead_tgt_q <= dead_tgt_d;
      dt_cnt_q   <= dt_cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign gate_h       = pat_q[5:3] & {3{pwm_in}};
  assign gate_l       = pat_q[2:0];
  assign sector       = sector_q;
  assign hall_fault   = hall_fault_q;
  assign step_error   = step_err_q;
  assign step_count   = step_count_q;
  assign step_period  = step_period_q;
  assign period_valid = period_valid_q;

endmodule

// File: tb/tb_bldc_commutator.sv
// Testbench for bldc_commutator. Stimulus pushes expected sector events and
// gate-pattern events into two queues; two monitors pop and compare whenever
// the sector or the gate outputs change, including the latency from the
// causing stimulus.

module tb_bldc_commutator;

  localparam int FILT = 4;
  localparam int DW   = 10;
  localparam int PW   = 12;

  logic          CLK = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    hall = 3'b101;
  logic          enable = 1'b1;
  logic          dir = 1'b1;
  logic          brake = 1'b0;
  logic [DW-1:0] deadtime = DW'(10);
  logic          pwm_in = 1'b1;
  logic [2:0]    gate_h, gate_l, sector;
  logic          hall_fault, step_error, period_valid;
  logic [31:0]   step_count;
  logic [PW-1:0] step_period;

  bldc_commutator #(
    .HALL_FILTER_CYCLES(FILT),
    .DEADTIME_WIDTH(DW),
    .PERIOD_WIDTH(PW)
  ) dut (
    .CLK(CLK), .reset_n(reset_n), .hall(hall), .enable(enable), .dir(dir),
    .brake(brake), .deadtime(deadtime), .pwm_in(pwm_in),
    .gate_h(gate_h), .gate_l(gate_l), .sector(sector),
    .hall_fault(hall_fault), .step_error(step_error),
    .step_count(step_count), .step_period(step_period),
    .period_valid(period_valid)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] sec;
    logic       fault;
    int         cnt;
    logic       err;
    logic       pv;
    int         per;
    int         lat;
  } sec_exp_t;

  typedef struct {
    logic [2:0] h;
    logic [2:0] l;
    int         lat;
  } gate_exp_t;

  sec_exp_t  sq[$];
  gate_exp_t gq[$];

  int n_checks = 0;
  int n_fail   = 0;
  int hall_cyc = 0;
  int sec_ref  = 0;
  int stim_ref = 0;
  bit mon_en   = 1'b0;

  // Sector order A..F
  logic [2:0] hall_of [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
  logic [2:0] fwd_h   [6] = '{3'b001, 3'b100, 3'b100, 3'b010, 3'b010, 3'b001};
  logic [2:0] fwd_l   [6] = '{3'b010, 3'b010, 3'b001, 3'b001, 3'b100, 3'b100};
  logic [2:0] rev_h   [6] = '{3'b010, 3'b010, 3'b001, 3'b001, 3'b100, 3'b100};
  logic [2:0] rev_l   [6] = '{3'b001, 3'b100, 3'b100, 3'b010, 3'b010, 3'b001};

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_s(input int sec, input bit fault, input int cnt, input bit err,
                        input bit pv, input int per, input int lat);
    sec_exp_t e;
    e.sec = 3'(sec); e.fault = fault; e.cnt = cnt; e.err = err;
    e.pv = pv; e.per = per; e.lat = lat;
    sq.push_back(e);
  endtask

  task automatic push_g(input logic [2:0] h, input logic [2:0] l, input int lat);
    gate_exp_t e;
    e.h = h; e.l = l; e.lat = lat;
    gq.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic set_hall(input logic [2:0] code);
    hall = code;
    hall_cyc = cyc;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sector"}, sector, 7);
    check({tag, "_hall_fault"}, hall_fault, 0);
    check({tag, "_step_error"}, step_error, 0);
    check({tag, "_step_count"}, step_count, 0);
    check({tag, "_step_period"}, step_period, 0);
    check({tag, "_period_valid"}, period_valid, 0);
    check({tag, "_gate_h"}, gate_h, 0);
    check({tag, "_gate_l"}, gate_l, 0);
  endtask

  // Sector monitor
  logic [2:0] prev_sec = 3'd7;
  always @(negedge CLK) begin : mon_sector
    sec_exp_t e;
    if (mon_en && sector != prev_sec) begin
      if (sq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sector_unexpected: got sector %0d, expected no change from %0d", sector, prev_sec);
      end else begin
        e = sq.pop_front();
        check("sector", sector, e.sec);
        check("hall_fault", hall_fault, e.fault);
        check("step_count", longint'($signed(step_count)), e.cnt);
        check("step_error", step_error, e.err);
        check("period_valid", period_valid, e.pv);
        if (e.pv) check("step_period", step_period, e.per);
        if (e.lat >= 0) check("sector_latency", cyc - hall_cyc, e.lat);
      end
      sec_ref = cyc;
    end
    prev_sec = sector;
  end

  // Gate monitor
  logic [5:0] prev_g = 6'd0;
  always @(negedge CLK) begin : mon_gate
    gate_exp_t e;
    int        ref_c;
    if (mon_en && {gate_h, gate_l} != prev_g) begin
      if (gq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL gate_unexpected: got h=%b l=%b, expected no change", gate_h, gate_l);
      end else begin
        e = gq.pop_front();
        ref_c = (sec_ref > stim_ref) ? sec_ref : stim_ref;
        check("gate_h", gate_h, e.h);
        check("gate_l", gate_l, e.l);
        check("gate_shoot_through", gate_h & gate_l, 0);
        if (e.lat >= 0) check("gate_latency", cyc - ref_c, e.lat);
      end
    end
    prev_g = {gate_h, gate_l};
  end

  initial begin
    wait_cyc(5);
    check_reset_outputs("reset");
    mon_en = 1'b1;

    // Startup in sector A, forward, dead time 10
    push_s(0, 0, 0, 0, 0, 0, 2 + FILT);
    push_g(fwd_h[0], fwd_l[0], 11);
    reset_n = 1'b1;
    hall_cyc = cyc;
    wait_cyc(1000);

    // Forward rotation A->B->...->F->A, 1000 cycles per step
    for (int k = 1; k <= 6; k++) begin
      push_s(k % 6, 0, k, 0, (k >= 2), 1000, 2 + FILT);
      push_g(3'b000, 3'b000, 1);
      push_g(fwd_h[k % 6], fwd_l[k % 6], 11);
      set_hall(hall_of[k % 6]);
      wait_cyc((k == 6) ? 500 : 1000);
    end

    // Direction change while driving A
    push_g(3'b000, 3'b000, 1);
    push_g(rev_h[0], rev_l[0], 11);
    stim_ref = cyc;
    dir = 1'b0;
    wait_cyc(500);

    // Reverse rotation A->F->E
    push_s(5, 0, 5, 0, 1, 1000, 2 + FILT);
    push_g(3'b000, 3'b000, 1);
    push_g(rev_h[5], rev_l[5], 11);
    set_hall(hall_of[5]);
    wait_cyc(1000);
    push_s(4, 0, 4, 0, 1, 1000, 2 + FILT);
    push_g(3'b000, 3'b000, 1);
    push_g(rev_h[4], rev_l[4], 11);
    set_hall(hall_of[4]);
    wait_cyc(1000);

    // Glitch shorter than the filter: no events expected
    hall = 3'b111;
    wait_cyc(3);
    hall = hall_of[4];
    wait_cyc(50);

    // Non-adjacent jump E->B
    push_s(1, 0, 4, 1, 1, 1000, 2 + FILT);
    push_g(3'b000, 3'b000, 1);
    push_g(rev_h[1], rev_l[1], 11);
    set_hall(hall_of[1]);
    wait_cyc(1000);

    // Invalid hall code and recovery
    push_s(7, 1, 4, 0, 1, 1000, 2 + FILT);
    push_g(3'b000, 3'b000, 1);
    set_hall(3'b000);
    wait_cyc(100);
    push_s(1, 0, 4, 0, 1, 1000, 2 + FILT);
    push_g(rev_h[1], rev_l[1], 11);
    set_hall(hall_of[1]);
    wait_cyc(100);

    // Brake with dead time 3, release with dead time 0 (acts as 1)
    deadtime = DW'(3);
    push_g(3'b000, 3'b000, 1);
    push_g(3'b000, 3'b111, 4);
    stim_ref = cyc;
    brake = 1'b1;
    wait_cyc(50);
    push_g(3'b000, 3'b000, 1);
    push_g(rev_h[1], rev_l[1], 2);
    stim_ref = cyc;
    deadtime = '0;
    brake = 1'b0;
    wait_cyc(50);

    // PWM gates only the high sides
    push_g(3'b000, rev_l[1], -1);
    pwm_in = 1'b0;
    wait_cyc(5);
    push_g(rev_h[1], rev_l[1], -1);
    pwm_in = 1'b1;
    wait_cyc(5);

    // Period counter saturation
    check("pv_before_sat", period_valid, 1);
    check("period_before_sat", step_period, 1000);
    wait_cyc(4200);
    check("pv_after_sat", period_valid, 0);

    // First step after saturation keeps period_valid low, next one reports
    push_s(2, 0, 5, 0, 0, 0, 2 + FILT);
    push_g(3'b000, 3'b000, 1);
    push_g(rev_h[2], rev_l[2], 2);
    set_hall(hall_of[2]);
    wait_cyc(1000);
    push_s(3, 0, 6, 0, 1, 1000, 2 + FILT);
    push_g(3'b000, 3'b000, 1);
    push_g(rev_h[3], rev_l[3], 2);
    set_hall(hall_of[3]);
    wait_cyc(1000);

    // Reset asserted in the middle of a dead period
    deadtime = DW'(10);
    push_s(2, 0, 5, 0, 1, 1000, 2 + FILT);
    push_g(3'b000, 3'b000, 1);
    set_hall(hall_of[2]);
    wait_cyc(10);
    push_s(7, 0, 0, 0, 0, 0, -1);
    reset_n = 1'b0;
    wait_cyc(3);
    check_reset_outputs("mid_dead_reset");
    check("sector_queue_drained", sq.size(), 0);
    check("gate_queue_drained", gq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
